// File: rtl/multichannel_mem_responder_if.sv
// Request/response bundle between a multi-channel memory client and the
// shared-memory responder. Every channel carries an independent read port and
// write port; a single backdoor preload port is shared.
interface multichannel_mem_responder_if #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4
);
    logic [NUM_CHANNELS-1:0]                 mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]                 mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;

    logic [NUM_CHANNELS-1:0]                 mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_ready;

    logic                                    init_write_valid;
    logic [ADDR_BITS-1:0]                    init_write_address;
    logic [DATA_BITS-1:0]                    init_write_data;

    // Requester side: issues requests and preloads, receives responses.
    modport master (
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready,
        output init_write_valid, init_write_address, init_write_data
    );

    // Responder side: owns the storage array and answers requests.
    modport slave (
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready,
        input  init_write_valid, init_write_address, init_write_data
    );
endinterface

// File: rtl/multichannel_mem_responder.sv
// Shared single-array memory answering NUM_CHANNELS independent request
// channels. Each channel accepts one read or write at a time, waits LATENCY
// cycles, then holds its ready (and read data) until the requester drops valid.
// A backdoor preload port writes the array directly, even during reset.
module multichannel_mem_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 2
) (
    input  logic clk,
    input  logic reset,
    multichannel_mem_responder_if.slave bus
);
    localparam int         MEM_WORDS = 2 ** ADDR_BITS;
    localparam logic [3:0] LAT_M1    = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    // Storage kept as a packed 2-D vector so per-channel write ports can be
    // resolved by loop order inside a single clocked process.
    logic [MEM_WORDS-1:0][DATA_BITS-1:0]    r_mem;

    logic [NUM_CHANNELS-1:0]                w_mem_we;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] w_mem_addr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] w_mem_data;

    genvar g;
    generate
        for (g = 0; g < NUM_CHANNELS; g++) begin : g_ch
            state_t               r_state, w_state_next;
            logic [3:0]           r_cnt, w_cnt_next;
            logic                 r_is_write, w_is_write_next;
            logic [ADDR_BITS-1:0] r_addr, w_addr_next;
            logic [DATA_BITS-1:0] r_wdata, w_wdata_next;
            logic                 r_rd_ready, w_rd_ready_next;
            logic                 r_wr_ready, w_wr_ready_next;
            logic [DATA_BITS-1:0] r_rd_data, w_rd_data_next;
            logic                 w_req_valid;
            logic                 w_we;

            // Next-state, counter, latch and response logic for one channel.
            always_comb begin
                w_state_next    = r_state;
                w_cnt_next      = r_cnt;
                w_is_write_next = r_is_write;
                w_addr_next     = r_addr;
                w_wdata_next    = r_wdata;
                w_rd_ready_next = r_rd_ready;
                w_wr_ready_next = r_wr_ready;
                w_rd_data_next  = r_rd_data;
                w_we            = 1'b0;
                // The valid that keeps the in-flight request alive depends
                // on which kind of request was accepted.
                if (r_is_write) begin
                    w_req_valid = bus.mem_write_valid[g];
                end else begin
                    w_req_valid = bus.mem_read_valid[g];
                end

                case (r_state)
                    ST_IDLE: begin
                        w_rd_ready_next = 1'b0;
                        w_wr_ready_next = 1'b0;
                        // Read has priority; a concurrent write waits for a
                        // later visit to IDLE.
                        if (bus.mem_read_valid[g]) begin
                            w_addr_next     = bus.mem_read_address[g];
                            w_cnt_next      = LAT_M1;
                            w_is_write_next = 1'b0;
                            w_state_next    = ST_BUSY;
                        end else if (bus.mem_write_valid[g]) begin
                            w_addr_next     = bus.mem_write_address[g];
                            w_wdata_next    = bus.mem_write_data[g];
                            w_cnt_next      = LAT_M1;
                            w_is_write_next = 1'b1;
                            w_state_next    = ST_BUSY;
                        end else begin
                            w_state_next    = ST_IDLE;
                        end
                    end
                    ST_BUSY: begin
                        if (!w_req_valid) begin
                            // Abort: no response, no array update.
                            w_cnt_next   = 4'd0;
                            w_state_next = ST_IDLE;
                        end else if (r_cnt == 4'd0) begin
                            w_state_next = ST_RESPOND;
                            if (r_is_write) begin
                                w_wr_ready_next = 1'b1;
                                w_we            = 1'b1;
                            end else begin
                                w_rd_ready_next = 1'b1;
                                w_rd_data_next  = r_mem[r_addr];
                            end
                        end else begin
                            w_cnt_next = r_cnt - 4'd1;
                        end
                    end
                    ST_RESPOND: begin
                        if (!w_req_valid) begin
                            w_rd_ready_next = 1'b0;
                            w_wr_ready_next = 1'b0;
                            w_state_next    = ST_IDLE;
                        end else begin
                            w_state_next    = ST_RESPOND;
                        end
                    end
                    default: begin
                        w_rd_ready_next = 1'b0;
                        w_wr_ready_next = 1'b0;
                        w_cnt_next      = 4'd0;
                        w_state_next    = ST_IDLE;
                    end
                endcase
            end

            // Channel state register; reset discards any in-flight request.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state    <= ST_IDLE;
                    r_cnt      <= 4'd0;
                    r_is_write <= 1'b0;
                    r_addr     <= '0;
                    r_wdata    <= '0;
                    r_rd_ready <= 1'b0;
                    r_wr_ready <= 1'b0;
                    r_rd_data  <= '0;
                end else begin
                    r_state    <= w_state_next;
                    r_cnt      <= w_cnt_next;
                    r_is_write <= w_is_write_next;
                    r_addr     <= w_addr_next;
                    r_wdata    <= w_wdata_next;
                    r_rd_ready <= w_rd_ready_next;
                    r_wr_ready <= w_wr_ready_next;
                    r_rd_data  <= w_rd_data_next;
                end
            end

            assign w_mem_we[g]             = w_we & ~reset;
            assign w_mem_addr[g]           = r_addr;
            assign w_mem_data[g]           = r_wdata;
            assign bus.mem_read_ready[g]   = r_rd_ready;
            assign bus.mem_write_ready[g]  = r_wr_ready;
            assign bus.mem_read_data[g]    = r_rd_data;
        end
    endgenerate

    // Array update: preload first, then channel writes in ascending index so
    // any channel beats the preload and the highest channel beats the rest.
    always_ff @(posedge clk) begin
        if (bus.init_write_valid) begin
            r_mem[bus.init_write_address] <= bus.init_write_data;
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_mem_we[i]) begin
                r_mem[w_mem_addr[i]] <= w_mem_data[i];
            end
        end
    end
endmodule

// File: tb/tb_multichannel_mem_responder.sv
// Directed bench for multichannel_mem_responder: a reference array model feeds
// an expected-read-data queue that is drained as responses appear.
module tb_multichannel_mem_responder;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int NC  = 4;
    localparam int LAT = 2;

    logic clk;
    logic reset;

    multichannel_mem_responder_if #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CHANNELS(NC)) bus ();

    multichannel_mem_responder #(
        .ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CHANNELS(NC), .LATENCY(LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [DW-1:0] model [2**AW];
    logic [DW-1:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.init_write_valid   = 1'b1;
        bus.init_write_address = a;
        bus.init_write_data    = d;
        model[a]               = d;
        @(negedge clk);
        bus.init_write_valid   = 1'b0;
    endtask

    task automatic do_read(input int ch, input logic [AW-1:0] a, input string tag);
        int k;
        logic [DW-1:0] expd;
        k = 0;
        bus.mem_read_address[ch] = a;
        bus.mem_read_valid[ch]   = 1'b1;
        exp_q.push_back(model[a]);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.mem_read_ready[ch]) begin
                k = c;
                break;
            end
        end
        check({tag, " rd latency"}, k, LAT + 1);
        expd = exp_q.pop_front();
        check({tag, " rd data"}, bus.mem_read_data[ch], expd);
        bus.mem_read_valid[ch] = 1'b0;
        @(negedge clk);
        check({tag, " rd ready clear"}, bus.mem_read_ready[ch], 1'b0);
        check({tag, " rd data hold"}, bus.mem_read_data[ch], expd);
        @(negedge clk);
    endtask

    task automatic do_write(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        int k;
        k = 0;
        bus.mem_write_address[ch] = a;
        bus.mem_write_data[ch]    = d;
        bus.mem_write_valid[ch]   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.mem_write_ready[ch]) begin
                k = c;
                break;
            end
        end
        check({tag, " wr latency"}, k, LAT + 1);
        check({tag, " no rd ready"}, bus.mem_read_ready[ch], 1'b0);
        model[a] = d;
        bus.mem_write_valid[ch] = 1'b0;
        @(negedge clk);
        check({tag, " wr ready clear"}, bus.mem_write_ready[ch], 1'b0);
        @(negedge clk);
    endtask

    initial begin
        int k;
        reset                 = 1'b1;
        bus.mem_read_valid    = '0;
        bus.mem_read_address  = '0;
        bus.mem_write_valid   = '0;
        bus.mem_write_address = '0;
        bus.mem_write_data    = '0;
        bus.init_write_valid  = 1'b0;
        bus.init_write_address = '0;
        bus.init_write_data   = '0;

        // Reset state, with a preload sampled during reset.
        @(negedge clk);
        preload(8'h10, 8'hA5);
        check("reset rd_ready", 32'(bus.mem_read_ready), 32'h0);
        check("reset wr_ready", 32'(bus.mem_write_ready), 32'h0);
        check("reset rd_data", 32'(bus.mem_read_data), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        preload(8'h30, 8'h5A);
        preload(8'h40, 8'hC3);

        // Basic read of the reset-time preload.
        do_read(0, 8'h10, "rd 0x10");

        // Write on one channel, read back on another.
        do_write(1, 8'h20, 8'h3C, "wr 0x20");
        do_read(2, 8'h20, "rd 0x20");

        // Same-edge writes from ch0 and ch3 to one address: ch3 wins.
        bus.mem_write_address[0] = 8'h05; bus.mem_write_data[0] = 8'h11;
        bus.mem_write_address[3] = 8'h05; bus.mem_write_data[3] = 8'h22;
        bus.mem_write_valid[0] = 1'b1;
        bus.mem_write_valid[3] = 1'b1;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.mem_write_ready[0]) begin
                k = c;
                break;
            end
        end
        check("dual wr ch0 latency", k, LAT + 1);
        check("dual wr ch3 ready", bus.mem_write_ready[3], 1'b1);
        model[8'h05] = 8'h22;
        bus.mem_write_valid[0] = 1'b0;
        bus.mem_write_valid[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_read(1, 8'h05, "rd 0x05");

        // Read and write both valid on ch0: read first, write after IDLE.
        bus.mem_read_address[0]  = 8'h10;
        bus.mem_write_address[0] = 8'h10;
        bus.mem_write_data[0]    = 8'h99;
        bus.mem_read_valid[0]    = 1'b1;
        bus.mem_write_valid[0]   = 1'b1;
        exp_q.push_back(model[8'h10]);
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.mem_read_ready[0]) begin
                k = c;
                break;
            end
        end
        check("rw rd latency", k, LAT + 1);
        check("rw rd data", bus.mem_read_data[0], exp_q.pop_front());
        check("rw wr held off", bus.mem_write_ready[0], 1'b0);
        bus.mem_read_valid[0] = 1'b0;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.mem_write_ready[0]) begin
                k = c;
                break;
            end
        end
        check("rw wr latency", k, LAT + 2);
        check("rw rd data kept", bus.mem_read_data[0], 8'hA5);
        model[8'h10] = 8'h99;
        bus.mem_write_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_read(2, 8'h10, "rd 0x10 new");

        // Write aborted in BUSY: no ready, array unchanged.
        bus.mem_write_address[0] = 8'h30;
        bus.mem_write_data[0]    = 8'h77;
        bus.mem_write_valid[0]   = 1'b1;
        @(negedge clk);
        bus.mem_write_valid[0]   = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.mem_write_ready[0]) k++;
        end
        check("abort no ready", k, 0);
        do_read(0, 8'h30, "rd 0x30 after abort");

        // Channel write beats a same-edge preload to the same address.
        bus.init_write_valid   = 1'b1;
        bus.init_write_address = 8'h50;
        bus.init_write_data    = 8'h55;
        bus.mem_write_address[2] = 8'h50;
        bus.mem_write_data[2]    = 8'h44;
        bus.mem_write_valid[2]   = 1'b1;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.mem_write_ready[2]) begin
                k = c;
                break;
            end
        end
        bus.init_write_valid = 1'b0;
        check("init race wr latency", k, LAT + 1);
        model[8'h50] = 8'h44;
        bus.mem_write_valid[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_read(3, 8'h50, "rd 0x50");

        // Reset while ch3 read and ch1 write are in BUSY.
        bus.mem_read_address[3]  = 8'h40;
        bus.mem_read_valid[3]    = 1'b1;
        bus.mem_write_address[1] = 8'h40;
        bus.mem_write_data[1]    = 8'hEE;
        bus.mem_write_valid[1]   = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.mem_read_ready != '0 || bus.mem_write_ready != '0) k++;
        end
        check("reset mid-op readies", k, 0);
        check("reset mid-op rd_data", 32'(bus.mem_read_data), 32'h0);
        bus.mem_read_valid[3]  = 1'b0;
        bus.mem_write_valid[1] = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        do_read(3, 8'h40, "rd 0x40 after reset");
        do_read(0, 8'h10, "rd 0x10 after reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
